// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared encodings for the MIPS multiply/divide unit: op codes, FSM states
// and the fixed iteration count of the radix-2 cores.
package mips_cpu_muldiv_pkg;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } muldiv_state_e;

endpackage

// File: rtl/mips_cpu_udiv_iter.sv
// Unsigned restoring divider, one quotient bit per clock. done flags the
// final step; quotient/remainder are valid from the following cycle.
module mips_cpu_udiv_iter
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] quo_reg, rem_reg, dvs_reg;
  logic [4:0]  cnt_reg;
  logic        run_reg;
  logic [33:0] diff;

  // Trial subtract of the shifted partial remainder; bit 33 is the borrow.
  assign diff      = {1'b0, rem_reg, quo_reg[31]} - {2'b00, dvs_reg};
  assign done      = run_reg && (cnt_reg == 5'(MULDIV_ITERS - 1));
  assign quotient  = quo_reg;
  assign remainder = rem_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_reg <= '0;
      rem_reg <= '0;
      dvs_reg <= '0;
      cnt_reg <= '0;
      run_reg <= 1'b0;
    end else if (start) begin
      quo_reg <= dividend;
      rem_reg <= '0;
      dvs_reg <= divisor;
      cnt_reg <= '0;
      run_reg <= 1'b1;
    end else if (run_reg) begin
      quo_reg <= {quo_reg[30:0], ~diff[33]};
      rem_reg <= diff[33] ? {rem_reg[30:0], quo_reg[31]} : diff[31:0];
      cnt_reg <= cnt_reg + 5'd1;
      if (done) run_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO multiply/divide unit: sign handling, shift-add multiplier and
// the control FSM around an unsigned iterative divider.
module mips_cpu_muldiv
  import mips_cpu_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  muldiv_state_e state_reg, state_next;
  muldiv_op_e    op_dec;

  logic [31:0] a_reg, b_reg, mcand_reg, hi_reg, lo_reg;
  logic [63:0] prod_reg, prod_fix;
  logic [5:0]  cnt_reg;
  logic        a_neg_reg, b_neg_reg, is_div_reg;
  logic        signed_op, div_start, div_done;
  logic [31:0] a_mag, b_mag, quo, rem, res_hi, res_lo;
  logic [32:0] mul_sum;

  assign op_dec    = muldiv_op_e'(op);
  assign signed_op = (op_dec == OP_MULT) || (op_dec == OP_DIV);
  assign a_mag     = a_neg_reg ? -a_reg : a_reg;
  assign b_mag     = b_neg_reg ? -b_reg : b_reg;
  assign mul_sum   = {1'b0, prod_reg[63:32]} + (prod_reg[0] ? {1'b0, mcand_reg} : 33'd0);
  assign prod_fix  = (a_neg_reg ^ b_neg_reg) ? -prod_reg : prod_reg;

  mips_cpu_udiv_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .quotient  (quo),
    .remainder (rem),
    .done      (div_done)
  );

  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = op_dec[1] ? DIV : MUL;
      MUL:  if (cnt_reg == 6'(MULDIV_ITERS)) state_next = DONE;
      DIV: begin
        div_start = (cnt_reg == 6'd0);
        if (div_done) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Sign fix-up; divide-by-zero returns the raw dividend in HI and all ones in LO.
  always_comb begin
    res_hi = prod_fix[63:32];
    res_lo = prod_fix[31:0];
    if (is_div_reg) begin
      if (b_reg == 32'd0) begin
        res_hi = a_reg;
        res_lo = 32'hFFFF_FFFF;
      end else begin
        res_hi = a_neg_reg ? -rem : rem;
        res_lo = (a_neg_reg ^ b_neg_reg) ? -quo : quo;
      end
    end
  end

  assign busy   = (state_reg != IDLE);
  assign done   = (state_reg == DONE);
  assign hi_out = done ? res_hi : hi_reg;
  assign lo_out = done ? res_lo : lo_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      mcand_reg  <= '0;
      prod_reg   <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      cnt_reg    <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      is_div_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (start) begin
          a_reg      <= a;
          b_reg      <= b;
          a_neg_reg  <= signed_op & a[31];
          b_neg_reg  <= signed_op & b[31];
          is_div_reg <= op_dec[1];
          cnt_reg    <= '0;
        end
        MUL: begin
          cnt_reg <= cnt_reg + 6'd1;
          // First cycle loads magnitudes; the remaining 32 are shift-add steps.
          if (cnt_reg == 6'd0) begin
            prod_reg  <= {32'd0, a_mag};
            mcand_reg <= b_mag;
          end else begin
            prod_reg <= {mul_sum, prod_reg[31:1]};
          end
        end
        DIV: cnt_reg <= cnt_reg + 6'd1;
        DONE: begin
          hi_reg <= res_hi;
          lo_reg <= res_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed self-checking bench for mips_cpu_muldiv.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  mips_cpu_muldiv dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .hi_out (hi_out),
    .lo_out (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one op from IDLE and waits for done; lat=-1 if done never comes.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic bz);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; h = 'x; l = 'x; bz = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; h = hi_out; l = lo_out; bz = busy;
        break;
      end
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h latency=%0d", o, x, y, h, l, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (hi_out !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi_out); end
    checks++; if (lo_out !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo_out); end
    // Reset together with start must win.
    @(negedge clk); start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_with_start: busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat; logic [31:0] h, l; logic bz;
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, h, l, bz);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
    checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", h); end
    checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", l); end
    checks++; if (bz !== 1'b1) begin errors++; $display("FAIL multu_busy_at_done: got %b want 1", bz); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL multu_after_done: done=%b busy=%b want 0 0", done, busy); end
    checks++; if (hi_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hold_hi: got %h want fffffffe", hi_out); end
  endtask

  task automatic test_mult_div_signed();
    int lat; logic [31:0] h, l; logic bz;
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, lat, h, l, bz);
    checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", h, l); end
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, lat, h, l, bz);
    checks++; if (l !== 32'hFFFF_FFFD || h !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", h, l); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, lat, h, l, bz);
    checks++; if (l !== 32'hFFFF_FFFD || h !== 32'h0000_0001) begin errors++; $display("FAIL div_neg_divisor: got hi=%h lo=%h want 00000001 fffffffd", h, l); end
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, h, l, bz);
    checks++; if (h !== 32'h4000_0000 || l !== 32'h0) begin errors++; $display("FAIL mult_minint: got %h_%h want 40000000_00000000", h, l); end
  endtask

  task automatic test_divu();
    int lat; logic [31:0] h, l; logic bz;
    run_op(2'b11, 32'd7, 32'd2, lat, h, l, bz);
    checks++; if (l !== 32'd3 || h !== 32'd1) begin errors++; $display("FAIL divu_7_2: got hi=%h lo=%h want 1 3", h, l); end
    run_op(2'b11, 32'd5, 32'd0, lat, h, l, bz);
    checks++; if (l !== 32'hFFFF_FFFF || h !== 32'd5) begin errors++; $display("FAIL divu_by_zero: got hi=%h lo=%h want 5 ffffffff", h, l); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_by_zero_latency: got %0d want 33", lat); end
    run_op(2'b10, 32'hFFFF_FFF0, 32'd0, lat, h, l, bz);
    checks++; if (l !== 32'hFFFF_FFFF || h !== 32'hFFFF_FFF0) begin errors++; $display("FAIL div_by_zero_signed: got hi=%h lo=%h want fffffff0 ffffffff", h, l); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, h, l, bz);
    checks++; if (l !== 32'h8000_0000 || h !== 32'h0) begin errors++; $display("FAIL div_overflow: got hi=%h lo=%h want 0 80000000", h, l); end
  endtask

  task automatic test_ignore_start();
    int ndone = 0; int first = -1;
    logic [31:0] h = 'x, l = 'x;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) a = 32'd9;
      if (k == 10) begin a = 32'h55; b = 32'h77; op = 2'b00; end
      @(posedge clk); #1;
      if (k == 10) begin
        checks++; if (lo_out !== 32'h8000_0000) begin errors++; $display("FAIL hold_during_op: lo got %h want 80000000", lo_out); end
      end
      if (done) begin
        ndone++;
        if (first < 0) begin first = k; h = hi_out; l = lo_out; end
      end
    end
    $display("multu 3*4 with stray start: dones=%0d first=%0d hi=%h lo=%h", ndone, first, h, l);
    checks++; if (ndone !== 1) begin errors++; $display("FAIL ignore_start_count: got %0d want 1", ndone); end
    checks++; if (h !== 32'd0 || l !== 32'd12) begin errors++; $display("FAIL ignore_start_result: got hi=%h lo=%h want 0 c", h, l); end
    checks++; if (first !== 33) begin errors++; $display("FAIL ignore_start_latency: got %0d want 33", first); end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    $display("div 100/7 aborted by reset: dones=%0d hi=%h lo=%h", ndone, hi_out, lo_out);
    checks++; if (ndone !== 0) begin errors++; $display("FAIL reset_mid_done: got %0d want 0", ndone); end
    checks++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin errors++; $display("FAIL reset_mid_outputs: got hi=%h lo=%h want 0 0", hi_out, lo_out); end
  endtask

  task automatic test_back_to_back();
    int times[4];
    int n = 0;
    @(negedge clk);
    start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd3;
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (done) begin
        $display("back_to_back done at cycle %0d lo=%h", c, lo_out);
        checks++; if (lo_out !== 32'd6) begin errors++; $display("FAIL b2b_lo: got %h want 6", lo_out); end
        if (n < 4) times[n] = c;
        n++;
      end
    end
    start = 1'b0;
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
    if (n >= 3) begin
      checks++; if (times[0] !== 34) begin errors++; $display("FAIL b2b_first: got %0d want 34", times[0]); end
      checks++; if (times[1] - times[0] !== 35) begin errors++; $display("FAIL b2b_period1: got %0d want 35", times[1] - times[0]); end
      checks++; if (times[2] - times[1] !== 35) begin errors++; $display("FAIL b2b_period2: got %0d want 35", times[2] - times[1]); end
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_div_signed();
    test_divu();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv.md
MIPS_CPU_MULDIV -- requirements
Module: mips_cpu_muldiv

Interface
REQ-001 Parameters: none; operand width is fixed at 32 bits and iteration count at 32.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low reset: 0 = reset, sampled on posedge clk.
REQ-004 start  in  1  request a new operation; sampled only when busy=0.
REQ-005 op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  in  32  rs operand: multiplicand or dividend.
REQ-007 b  in  32  rt operand: multiplier or divisor.
REQ-008 busy  out  1  high whenever state != IDLE.
REQ-009 done  out  1  one-cycle pulse; hi_out/lo_out are valid and drive the HI/LO register enables.
REQ-010 hi_out  out  32  HI result: product[63:32] or remainder.
REQ-011 lo_out  out  32  LO result: product[31:0] or quotient.

Function
REQ-012 The FSM SHALL have exactly these states: IDLE, MUL, DIV, DONE.
REQ-013 IDLE with start=1 SHALL accept the request: latch a, b, op and sign flags, clear the iteration counter, go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-014 In IDLE, start=0 SHALL leave the block in IDLE.
REQ-015 MUL/DIV SHALL run exactly 32 iterations (radix-2 shift-add / restoring shift-subtract on unsigned magnitudes), then go to DONE.
REQ-016 DONE SHALL assert done for one cycle, update hi_out/lo_out, then go to IDLE.
REQ-017 Latency: if start is accepted at edge N, then done SHALL be high in the cycle after edge N+33, and busy SHALL be high from edge N+1 through the done cycle.
REQ-018 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-019 Changes on a, b or op after acceptance SHALL NOT affect the result.
REQ-020 Signed ops (MULT, DIV): take operand magnitudes (two's-complement negate if bit31=1), run the unsigned core, then apply the sign fix-up in DONE.
REQ-021 MULT product sign SHALL be a[31]^b[31], applied to the full 64 bits.
REQ-022 DIV quotient SHALL truncate toward zero with sign a[31]^b[31]; the remainder SHALL take the sign of a.
REQ-023 MULTU/DIVU SHALL NOT apply any sign fix-up.
REQ-024 Divide by zero, b=0 with DIV or DIVU: lo_out=0xFFFFFFFF, hi_out=a, with no sign fix-up and normal 33-cycle latency.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo_out=0x80000000 and hi_out=0, with no exception.
REQ-026 hi_out/lo_out SHALL hold the last result until the next DONE and SHALL NOT change during MUL/DIV.
REQ-027 Back-to-back: start in the first IDLE cycle after done SHALL be accepted.

Reset
REQ-028 On reset=0 at posedge: state=IDLE, busy=0, done=0, hi_out=0, lo_out=0, and all datapath registers cleared.
REQ-029 Reset mid-operation SHALL abort the operation: no done pulse, and the previous result is discarded (outputs become 0).
REQ-030 reset=0 together with start=1 SHALL resolve to reset; the request is not accepted.

Structure
REQ-031 Package mips_cpu_muldiv_pkg SHALL hold the op encoding enum, the FSM state enum and the constant MULDIV_ITERS=32.
REQ-032 The unsigned iterative divider step logic SHALL be sub-module mips_cpu_udiv_iter, with an interface of start, operands, quotient, remainder and done.
REQ-033 Multiplier, sign handling and FSM SHALL remain in mips_cpu_muldiv.

Verification
REQ-034 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi_out=0xFFFFFFFE, lo_out=0x00000001, done exactly 33 cycles after the accepting edge.
REQ-035 MULT a=0xFFFFFFFD b=0x00000007 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; then DIV a=0xFFFFFFF9 b=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF.
REQ-036 DIVU 7/2 -> lo_out=3, hi_out=1; DIVU 5/0 -> lo_out=0xFFFFFFFF, hi_out=5; DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
REQ-037 Start MULTU 3*4, pulse start with a=9 at iteration 5, and change a/b at iteration 10 -> a single done, with hi_out=0 and lo_out=12.
REQ-038 reset=0 at iteration 10 of DIV -> busy=0 next cycle, no done for 40 cycles, hi_out=lo_out=0.
REQ-039 start held high continuously with MULTU 2*3 -> done pulses every 35 cycles, each with lo_out=6; start accepted in the first IDLE cycle.
